// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencing controller:
// opcodes, stall-bus bit positions, handshake levels and FSM states.
package muldiv_ctrl_pkg;

  localparam logic [3:0] HILO_MULT  = 4'b0101;
  localparam logic [3:0] HILO_MULTU = 4'b0110;
  localparam logic [3:0] HILO_DIV   = 4'b0111;
  localparam logic [3:0] HILO_DIVU  = 4'b1000;

  // Bit 2 of the pipeline stall bus freezes EX.
  localparam int   STALL_EX_BIT = 2;
  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;

  localparam logic MIX_START     = 1'b1;
  localparam logic MIX_STOP      = 1'b0;
  localparam logic MIX_READY     = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == HILO_MULT) || (op == HILO_MULTU) ||
           (op == HILO_DIV)  || (op == HILO_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == HILO_DIV) || (op == HILO_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == HILO_MULT) || (op == HILO_DIV);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Handshake between the sequencing controller (master) and the shared
// iterative multiply/divide unit (slave).
interface muldiv_ctrl_if #(
  parameter int DATA_W = 32
);
  logic                  mix_start;
  logic                  mix_signed;
  logic                  mix_mul_div;
  logic [DATA_W-1:0]     mix_op1;
  logic [DATA_W-1:0]     mix_op2;
  logic                  mix_annul;
  logic [2*DATA_W-1:0]   mix_result;
  logic                  mix_ready;

  modport master (
    output mix_start, mix_signed, mix_mul_div, mix_op1, mix_op2, mix_annul,
    input  mix_result, mix_ready
  );

  modport slave (
    input  mix_start, mix_signed, mix_mul_div, mix_op1, mix_op2, mix_annul,
    output mix_result, mix_ready
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequences one HI/LO mul/div instruction through the shared unit, stalls EX
// while it runs and holds the 64-bit result until EX is released.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int STALL_W = 6,
  parameter int TIMEOUT = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic [3:0]            hilo_op,
  input  logic [DATA_W-1:0]     op1,
  input  logic [DATA_W-1:0]     op2,
  muldiv_ctrl_if.master         mix,
  output logic [2*DATA_W-1:0]   result,
  output logic                  result_valid,
  output logic                  stallreq,
  output logic                  timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [2*DATA_W-1:0]   result_reg;
  logic                  timeout_err_reg;
  logic                  start_reg;
  logic                  signed_reg;
  logic                  mul_div_reg;
  logic [DATA_W-1:0]     op1_reg;
  logic [DATA_W-1:0]     op2_reg;

  logic                  op_valid;
  logic                  div_zero;
  logic                  cnt_expired;
  logic                  ex_release;
  logic                  unused_stall_bits;

  assign op_valid    = is_muldiv(hilo_op);
  assign div_zero    = is_div(hilo_op) && (op2 == '0);
  assign cnt_expired = (cnt_reg == CNT_W'(TIMEOUT - 1));
  assign ex_release  = (stall[STALL_EX_BIT] == NO_STOP);
  assign unused_stall_bits = ^(stall & ~(STALL_W'(1) << STALL_EX_BIT));

  // Flush and reset must silence the pipeline-facing outputs in the same cycle.
  assign stallreq     = !rst && !flush &&
                        (((state_reg == ST_IDLE) && op_valid) || (state_reg == ST_RUN));
  assign result_valid = !rst && !flush && (state_reg == ST_DONE);
  assign mix.mix_annul = !rst && (state_reg == ST_RUN) &&
                         (flush || (cnt_expired && (mix.mix_ready != MIX_READY)));

  assign mix.mix_start   = start_reg;
  assign mix.mix_signed  = signed_reg;
  assign mix.mix_mul_div = mul_div_reg;
  assign mix.mix_op1     = op1_reg;
  assign mix.mix_op2     = op2_reg;
  assign result          = result_reg;
  assign timeout_err     = timeout_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      result_reg      <= '0;
      timeout_err_reg <= 1'b0;
      start_reg       <= MIX_STOP;
      signed_reg      <= 1'b0;
      mul_div_reg     <= 1'b0;
      op1_reg         <= '0;
      op2_reg         <= '0;
    end else if (flush) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      start_reg <= MIX_STOP;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (op_valid) begin
            op1_reg     <= op1;
            op2_reg     <= op2;
            signed_reg  <= is_signed_op(hilo_op);
            mul_div_reg <= is_div(hilo_op);
            cnt_reg     <= '0;
            // Divide by zero never reaches the unit; the result is fixed.
            if (div_zero) begin
              result_reg <= {op1, {DATA_W{1'b1}}};
              state_reg  <= ST_DONE;
            end else begin
              start_reg <= MIX_START;
              state_reg <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (mix.mix_ready == MIX_READY) begin
            result_reg <= mix.mix_result;
            start_reg  <= MIX_STOP;
            state_reg  <= ST_DONE;
          end else if (cnt_expired) begin
            result_reg      <= '0;
            timeout_err_reg <= 1'b1;
            start_reg       <= MIX_STOP;
            state_reg       <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // Result stays put while EX is frozen; the unit is not relaunched.
          if (ex_release) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl with a behavioural model of the mix unit
// and an arithmetic reference for the expected HI/LO results.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int DATA_W  = 32;
  localparam int STALL_W = 6;
  localparam int TIMEOUT = 40;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush = 1'b0;
  logic [STALL_W-1:0]   stall = '0;
  logic [3:0]           hilo_op = '0;
  logic [DATA_W-1:0]    op1 = '0;
  logic [DATA_W-1:0]    op2 = '0;
  logic [2*DATA_W-1:0]  result;
  logic                 result_valid;
  logic                 stallreq;
  logic                 timeout_err;

  int tests_run = 0;
  int tests_failed = 0;
  int mix_lat = 0;
  int mix_cnt = 0;

  muldiv_ctrl_if #(.DATA_W(DATA_W)) ifc();

  muldiv_ctrl #(
    .DATA_W (DATA_W),
    .STALL_W(STALL_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .hilo_op     (hilo_op),
    .op1         (op1),
    .op2         (op2),
    .mix         (ifc),
    .result      (result),
    .result_valid(result_valid),
    .stallreq    (stallreq),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // MIPS HI/LO semantics: product as {hi,lo}; quotient in lo, remainder in hi.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      HILO_MULT:  return 64'(sa * sb);
      HILO_MULTU: return ua * ub;
      HILO_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      HILO_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [3:0] mix_code(input logic sgn, input logic md);
    if (md) return sgn ? HILO_DIV : HILO_DIVU;
    return sgn ? HILO_MULT : HILO_MULTU;
  endfunction

  // Advance one clock; the mix model answers in its mix_lat-th start cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ifc.mix_start) begin
      mix_cnt++;
      if (mix_lat > 0 && mix_cnt == mix_lat) begin
        ifc.mix_ready  = 1'b1;
        ifc.mix_result = ref_result(mix_code(ifc.mix_signed, ifc.mix_mul_div),
                                    ifc.mix_op1, ifc.mix_op2);
      end else begin
        ifc.mix_ready  = 1'b0;
        ifc.mix_result = '0;
      end
    end else begin
      mix_cnt        = 0;
      ifc.mix_ready  = 1'b0;
      ifc.mix_result = '0;
    end
  endtask

  // Issues one instruction and measures what the DUT does until it is back in IDLE.
  task automatic run_one(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int hold,
                         output logic [63:0] res, output int first_valid, output int stall_cnt,
                         output int start_cnt, output int valid_cnt, output int hold_bad,
                         output int latch_bad, output bit done);
    logic exp_signed, exp_md;
    exp_signed  = (op == HILO_MULT) || (op == HILO_DIV);
    exp_md      = (op == HILO_DIV) || (op == HILO_DIVU);
    res         = '0;
    first_valid = -1;
    stall_cnt   = 0;
    start_cnt   = 0;
    valid_cnt   = 0;
    hold_bad    = 0;
    latch_bad   = 0;
    done        = 1'b0;
    mix_lat     = lat;
    stall[STALL_EX_BIT] = 1'b0;
    hilo_op = op;
    op1     = a;
    op2     = b;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (stallreq) stall_cnt++;
      if (ifc.mix_start) start_cnt++;
      if (ifc.mix_start || result_valid) begin
        if (ifc.mix_op1 !== a || ifc.mix_op2 !== b ||
            ifc.mix_signed !== exp_signed || ifc.mix_mul_div !== exp_md) latch_bad++;
      end
      if (result_valid) begin
        if (valid_cnt == 0) begin
          res = result;
          first_valid = c;
        end else if (result !== res) begin
          hold_bad++;
        end
        valid_cnt++;
        if (valid_cnt > hold) stall[STALL_EX_BIT] = 1'b0;
      end else if (valid_cnt > 0) begin
        done = 1'b1;
        break;
      end
      tick();
      if (c == 0) begin
        hilo_op = '0;
        op1 = $urandom;
        op2 = $urandom;
        stall[STALL_EX_BIT] = (hold > 0);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hilo_op = HILO_MULT;
    op1 = 32'd5;
    op2 = 32'd6;
    tick();
    tick();
    #1;
    tests_run++;
    if (stallreq !== 1'b0 || result_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: stallreq=%b result_valid=%b, required 0/0", stallreq, result_valid);
    end
    tests_run++;
    if (result !== 64'd0 || timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_result: result=%h timeout_err=%b, required 0/0", result, timeout_err);
    end
    tests_run++;
    if (ifc.mix_start !== 1'b0 || ifc.mix_annul !== 1'b0 || ifc.mix_op1 !== 32'd0 ||
        ifc.mix_op2 !== 32'd0 || ifc.mix_signed !== 1'b0 || ifc.mix_mul_div !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mix: start=%b annul=%b op1=%h op2=%h sgn=%b md=%b, required all 0",
               ifc.mix_start, ifc.mix_annul, ifc.mix_op1, ifc.mix_op2, ifc.mix_signed,
               ifc.mix_mul_div);
    end
    hilo_op = '0;
    rst = 1'b0;
    tick();
    $display("[TB] reset checked");
  endtask

  task automatic test_div_signed();
    logic [63:0] res;
    int fv, sc, stc, vc, hb, lb;
    bit done;
    run_one(HILO_DIV, 32'd100, 32'd7, 33, 0, res, fv, sc, stc, vc, hb, lb, done);
    $display("[TB] div 100/7 result=%h stall_cycles=%0d", res, sc);
    tests_run++;
    if (res !== {32'd2, 32'd14}) begin
      tests_failed++;
      $display("FAIL div_signed_result: got %h, required %h", res, {32'd2, 32'd14});
    end
    tests_run++;
    if (sc !== 34 || fv !== 34) begin
      tests_failed++;
      $display("FAIL div_signed_stall: stall cycles %0d first valid %0d, required 34/34", sc, fv);
    end
    tests_run++;
    if (stc !== 33 || lb !== 0 || !done) begin
      tests_failed++;
      $display("FAIL div_signed_handshake: start %0d latch_bad %0d done %0b, required 33/0/1",
               stc, lb, done);
    end
  endtask

  task automatic test_divu_zero();
    logic [63:0] res;
    int fv, sc, stc, vc, hb, lb;
    bit done;
    run_one(HILO_DIVU, 32'h1234_5678, 32'd0, 10, 0, res, fv, sc, stc, vc, hb, lb, done);
    $display("[TB] divu 0x12345678/0 result=%h", res);
    tests_run++;
    if (res !== {32'h1234_5678, 32'hFFFF_FFFF}) begin
      tests_failed++;
      $display("FAIL divu_zero_result: got %h, required %h", res, {32'h1234_5678, 32'hFFFF_FFFF});
    end
    tests_run++;
    if (stc !== 0 || fv !== 1 || sc !== 1 || !done) begin
      tests_failed++;
      $display("FAIL divu_zero_timing: start %0d first valid %0d stall %0d done %0b, required 0/1/1/1",
               stc, fv, sc, done);
    end
  endtask

  task automatic test_multu_hold();
    logic [63:0] res;
    int fv, sc, stc, vc, hb, lb;
    bit done;
    run_one(HILO_MULTU, 32'hFFFF_FFFF, 32'd2, 6, 3, res, fv, sc, stc, vc, hb, lb, done);
    $display("[TB] multu 0xFFFFFFFF*2 held result=%h valid_cycles=%0d", res, vc);
    tests_run++;
    if (res !== {32'd1, 32'hFFFF_FFFE}) begin
      tests_failed++;
      $display("FAIL multu_hold_result: got %h, required %h", res, {32'd1, 32'hFFFF_FFFE});
    end
    tests_run++;
    if (vc !== 4 || hb !== 0 || stc !== 6 || !done) begin
      tests_failed++;
      $display("FAIL multu_hold_freeze: valid %0d hold_bad %0d start %0d done %0b, required 4/0/6/1",
               vc, hb, stc, done);
    end
  endtask

  task automatic test_flush();
    stall = '0;
    mix_lat = 5;
    hilo_op = HILO_MULT;
    op1 = 32'hFFFF_FFFF;
    op2 = 32'hFFFF_FFFF;
    #1;
    tick();
    hilo_op = '0;
    for (int c = 1; c < 5; c++) tick();
    flush = 1'b1;
    #1;
    $display("[TB] mult -1*-1 flushed in RUN cycle 5");
    tests_run++;
    if (ifc.mix_annul !== 1'b1 || stallreq !== 1'b0 || result_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_cycle: annul=%b stallreq=%b valid=%b, required 1/0/0",
               ifc.mix_annul, stallreq, result_valid);
    end
    tick();
    flush = 1'b0;
    ifc.mix_ready  = 1'b1;
    ifc.mix_result = 64'hDEAD_BEEF_0BAD_F00D;
    #1;
    tests_run++;
    if (ifc.mix_annul !== 1'b0 || ifc.mix_start !== 1'b0 || stallreq !== 1'b0 ||
        result_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_after: annul=%b start=%b stallreq=%b valid=%b, required 0/0/0/0",
               ifc.mix_annul, ifc.mix_start, stallreq, result_valid);
    end
    tick();
    #1;
    tests_run++;
    if (result_valid !== 1'b0 || ifc.mix_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_late_ready: valid=%b start=%b, required 0/0", result_valid, ifc.mix_start);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] codes [4];
    logic [3:0] op;
    logic [31:0] a, b;
    logic [63:0] res, expv;
    int lat, hold, fv, sc, stc, vc, hb, lb;
    bit done, div0;
    codes[0] = HILO_MULT;
    codes[1] = HILO_MULTU;
    codes[2] = HILO_DIV;
    codes[3] = HILO_DIVU;
    for (int i = 0; i < 16; i++) begin
      op = codes[$urandom_range(0, 3)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'd0;
      else if ($urandom_range(0, 2) == 0) b = $urandom_range(1, 20);
      lat  = $urandom_range(1, 25);
      hold = $urandom_range(0, 3);
      stall = STALL_W'($urandom) & ~(STALL_W'(1) << STALL_EX_BIT);
      div0 = ((op == HILO_DIV) || (op == HILO_DIVU)) && (b == 32'd0);
      expv = ref_result(op, a, b);
      run_one(op, a, b, lat, hold, res, fv, sc, stc, vc, hb, lb, done);
      $display("[TB] op=%h a=%h b=%h lat=%0d hold=%0d result=%h", op, a, b, lat, hold, res);
      tests_run++;
      if (res !== expv) begin
        tests_failed++;
        $display("FAIL b2b_result[%0d]: got %h, required %h", i, res, expv);
      end
      tests_run++;
      if (sc !== (div0 ? 1 : lat + 1) || fv !== (div0 ? 1 : lat + 1) || stc !== (div0 ? 0 : lat)) begin
        tests_failed++;
        $display("FAIL b2b_timing[%0d]: stall %0d first %0d start %0d, required %0d/%0d/%0d",
                 i, sc, fv, stc, div0 ? 1 : lat + 1, div0 ? 1 : lat + 1, div0 ? 0 : lat);
      end
      tests_run++;
      if (vc !== hold + 1 || hb !== 0 || lb !== 0 || !done) begin
        tests_failed++;
        $display("FAIL b2b_hold[%0d]: valid %0d hold_bad %0d latch_bad %0d done %0b, required %0d/0/0/1",
                 i, vc, hb, lb, done, hold + 1);
      end
    end
    stall = '0;
  endtask

  task automatic test_timeout();
    int start_cnt, annul_cnt, annul_at, early_err;
    bit seen;
    logic [63:0] res;
    int fv, sc, stc, vc, hb, lb;
    bit done;
    start_cnt = 0; annul_cnt = 0; annul_at = -1; early_err = 0; seen = 1'b0;
    stall = '0;
    mix_lat = 0;
    hilo_op = HILO_MULT;
    op1 = 32'd5;
    op2 = 32'd6;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (ifc.mix_start) begin
        start_cnt++;
        if (timeout_err) early_err++;
      end
      if (ifc.mix_annul) begin
        annul_cnt++;
        annul_at = start_cnt;
      end
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
      hilo_op = '0;
    end
    $display("[TB] mult without ready: annul after %0d start cycles, timeout_err=%b", annul_at, timeout_err);
    tests_run++;
    if (!seen || result !== 64'd0 || timeout_err !== 1'b1 || early_err !== 0) begin
      tests_failed++;
      $display("FAIL timeout_done: seen=%0b result=%h err=%b early=%0d, required 1/0/1/0",
               seen, result, timeout_err, early_err);
    end
    tests_run++;
    if (annul_cnt !== 1 || annul_at !== TIMEOUT || start_cnt !== TIMEOUT) begin
      tests_failed++;
      $display("FAIL timeout_annul: pulses %0d at %0d starts %0d, required 1/%0d/%0d",
               annul_cnt, annul_at, start_cnt, TIMEOUT, TIMEOUT);
    end
    tick();
    run_one(HILO_MULT, 32'd3, 32'd4, 6, 0, res, fv, sc, stc, vc, hb, lb, done);
    $display("[TB] mult 3*4 after timeout result=%h", res);
    tests_run++;
    if (timeout_err !== 1'b1 || res !== 64'd12 || !done) begin
      tests_failed++;
      $display("FAIL timeout_sticky: err=%b result=%h done=%0b, required 1/%h/1", timeout_err, res, done,
               64'd12);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] res;
    int fv, sc, stc, vc, hb, lb;
    bit done;
    stall = '0;
    mix_lat = 30;
    hilo_op = HILO_MULT;
    op1 = 32'd7;
    op2 = 32'd9;
    #1;
    tick();
    hilo_op = '0;
    for (int c = 0; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (result !== 64'd0 || result_valid !== 1'b0 || stallreq !== 1'b0 || timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_out: result=%h valid=%b stallreq=%b err=%b, required 0/0/0/0",
               result, result_valid, stallreq, timeout_err);
    end
    tests_run++;
    if (ifc.mix_start !== 1'b0 || ifc.mix_annul !== 1'b0 || ifc.mix_op1 !== 32'd0 ||
        ifc.mix_signed !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_mix: start=%b annul=%b op1=%h sgn=%b, required 0/0/0/0",
               ifc.mix_start, ifc.mix_annul, ifc.mix_op1, ifc.mix_signed);
    end
    tick();
    run_one(HILO_MULT, 32'd3, 32'd4, 4, 0, res, fv, sc, stc, vc, hb, lb, done);
    $display("[TB] mult 3*4 after reset result=%h", res);
    tests_run++;
    if (res !== {32'd0, 32'd12} || fv !== 5 || !done) begin
      tests_failed++;
      $display("FAIL rst_mid_relaunch: result=%h first=%0d done=%0b, required %h/5/1",
               res, fv, done, {32'd0, 32'd12});
    end
  endtask

  initial begin
    ifc.mix_ready  = 1'b0;
    ifc.mix_result = '0;
    test_reset();
    test_div_signed();
    test_divu_zero();
    test_multu_hold();
    test_flush();
    test_back_to_back();
    test_timeout();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencing controller for the shared iterative multiply/divide unit (`mix`) used by the EX stage.
- Decodes the HI/LO opcode and latches operands at launch.
- Drives the unit's start/signed/mul_div/annul handshake, generates the EX stall request and short-circuits divide-by-zero.
- Holds the 64-bit result stable while EX is frozen by downstream stalls, so the unit is never relaunched for the same instruction.

Parameters:
DATA_W, 32, operand width; result is 2*DATA_W.
STALL_W, 6, width of the pipeline stall bus (`StallBus).
TIMEOUT, 40, max RUN cycles before the watchdog aborts the operation.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
stall  in  STALL_W  pipeline stall vector; bit 2 = EX stop (`Stop = 1).
flush  in  1  pipeline flush; kills any in-flight operation.
hilo_op  in  4  mult=0101, multu=0110, div=0111, divu=1000; other values = no mul/div.
op1  in  DATA_W  rs operand (dividend / multiplicand).
op2  in  DATA_W  rt operand (divisor / multiplier).
mix_start  out  1  start to `mix`; held high for the whole RUN state.
mix_signed  out  1  signed operation flag.
mix_mul_div  out  1  1 = divide, 0 = multiply.
mix_op1  out  DATA_W  latched op1.
mix_op2  out  DATA_W  latched op2.
mix_annul  out  1  one-cycle abort pulse to `mix`.
mix_result  in  2*DATA_W  {hi, lo} from `mix`.
mix_ready  in  1  `mix` result valid.
result  out  2*DATA_W  {hi, lo} for the HI/LO write path.
result_valid  out  1  result usable this cycle.
stallreq  out  1  EX stall request.
timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset: state IDLE. All outputs 0; counter 0; timeout_err cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - When hilo_op is valid and flush=0: stallreq=1 combinationally in the same cycle.
  - Latch op1/op2, signed = (mult|div), mul_div = (div|divu).
  - If divide with op2==0: go to DONE with result = {op1, all-ones} (hi = dividend, lo = 0xFFFFFFFF); mix_start is never asserted.
  - Otherwise go to RUN.
- RUN:
  - mix_start=1, stallreq=1, counter increments each cycle.
  - When mix_ready=1: register mix_result into result and go to DONE (mix_start drops that edge).
  - When counter==TIMEOUT-1 with no ready: timeout_err=1, result=0, pulse mix_annul, go to DONE.
- DONE:
  - result_valid=1, stallreq=0, mix_start=0.
  - If stall[2]==NoStop: go to IDLE (the instruction leaves EX this edge).
  - Otherwise hold state and result unchanged; no relaunch.
- Latency: divide-by-zero result is visible 1 cycle after issue. Otherwise latency is `mix` latency + 1 (registered capture).
- flush, any state: next state IDLE, result_valid=0, stallreq=0 the same cycle.
  - If the state was RUN, mix_annul=1 for exactly that cycle.
  - flush dominates mix_ready arriving in the same cycle; that result is discarded.
- mix_annul is otherwise 0; it is never asserted in IDLE or DONE except on a timeout.
- mix_op1/op2/signed/mul_div stay constant from launch until the controller returns to IDLE.
- Back-to-back mul/div instructions: DONE→IDLE→relaunch; at least one IDLE cycle between operations.
- Arithmetic is performed only inside `mix`; the controller does no width extension.

Decomposition:
- Shared defines.vh: `StallBus, `Stop/`NoStop, `MixStart/`MixStop, `MixResultReady/`MixResultNotReady, and the hilo_op encodings (HILO_MULT, HILO_MULTU, HILO_DIV, HILO_DIVU), plus FSM state encodings.
- No sub-module: the FSM, watchdog counter and result register stay inline; `mix` is instantiated by EX, not by this block.

Test Plan:
- div signed, op1=100, op2=7, model ready after 33 cycles -> stallreq high 34 cycles; then result={2,14}, result_valid=1, stallreq=0.
- divu, op1=0x12345678, op2=0 -> mix_start never high; 1 cycle later result={0x12345678,0xFFFFFFFF}.
- mult, op1=-1, op2=-1, flush asserted in RUN cycle 5 -> mix_annul one-cycle pulse, IDLE next cycle, stallreq=0, result_valid=0; a late mix_ready is ignored.
- multu, 0xFFFFFFFF*2 reaching DONE while stall[2]=1 for 3 cycles -> result={1,0xFFFFFFFE} held 3 cycles, no mix_start, then IDLE.
- mix_ready never asserted -> after 40 RUN cycles timeout_err=1 (sticky until rst), result=0, mix_annul pulse.
- rst asserted mid-RUN -> next cycle all outputs 0, state IDLE; a following mult 3*4 gives result={0,12}.
